// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
// Bundles the issue and write-back signals of the register file scoreboard.
//   instruction    : issued instruction word (rs1=[19:15], rs2=[24:20], rd=[11:7])
//   issue_valid    : instruction offered for issue
//   issue_rd_en    : the offered instruction writes rd
//   issue_ready    : issue accepted this cycle
//   read_data1/2   : rs1/rs2 operands, combinational
//   wb_valid/rd/data : write-back strobe, index and data
//   busy_vec       : per-register pending-write bits
//   pending_count  : number of set busy bits
//   wb_unexpected  : registered pulse, write-back to a non-busy register
// The master modport is the pipeline side, the slave modport is the scoreboard.
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
   parameter int DATA_W   = 64,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5
);
   logic [31:0]         instruction;
   logic                issue_valid;
   logic                issue_rd_en;
   logic                issue_ready;
   logic [DATA_W-1:0]   read_data1;
   logic [DATA_W-1:0]   read_data2;
   logic                wb_valid;
   logic [ADDR_W-1:0]   wb_rd;
   logic [DATA_W-1:0]   wb_data;
   logic [NUM_REGS-1:0] busy_vec;
   logic [ADDR_W:0]     pending_count;
   logic                wb_unexpected;

   modport master (
      output instruction, issue_valid, issue_rd_en, wb_valid, wb_rd, wb_data,
      input  issue_ready, read_data1, read_data2, busy_vec, pending_count, wb_unexpected
   );

   modport slave (
      input  instruction, issue_valid, issue_rd_en, wb_valid, wb_rd, wb_data,
      output issue_ready, read_data1, read_data2, busy_vec, pending_count, wb_unexpected
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Register file with a per-register busy scoreboard. Issue is refused on
// RAW or WAW hazards against outstanding writes; write-backs fill the
// register and clear its busy bit. Optional write-to-read forwarding.
// Ports:
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : regfile_scoreboard_if.slave (issue, operands, write-back, status)
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int          DATA_W   = 64,
   parameter int          NUM_REGS = 32,
   parameter int          ADDR_W   = 5,
   parameter int unsigned BYPASS   = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   regfile_scoreboard_if.slave  bus
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [ADDR_W:0]     pendingCount_q, pendingCount_d;
   logic                wbUnexpected_q, wbUnexpected_d;

   logic [4:0] rs1, rs2, rd;
   logic       wbWrite;
   logic       bypass1, bypass2;
   logic       raw1, raw2, waw, hazard, issueAccept;
   logic       unusedInstrBits;

   // An index names a real, writable register only if it is nonzero and
   // below NUM_REGS; everything else reads as zero and ignores writes.
   function automatic logic idxValid(input int idx);
      return (idx != 0) && (idx < NUM_REGS);
   endfunction

   assign rs1 = bus.instruction[19:15];
   assign rs2 = bus.instruction[24:20];
   assign rd  = bus.instruction[11:7];
   assign unusedInstrBits = ^{bus.instruction[31:25], bus.instruction[14:12], bus.instruction[6:0]};

   // Decode the write-back and the forwarding matches for each read port.
   always_comb begin
      wbWrite = bus.wb_valid && idxValid(int'(bus.wb_rd));
      bypass1 = (BYPASS != 0) && wbWrite && (int'(bus.wb_rd) == int'(rs1));
      bypass2 = (BYPASS != 0) && wbWrite && (int'(bus.wb_rd) == int'(rs2));
   end

   // Operand reads: zero for x0 and out-of-range, forwarded data when the
   // register is being written this cycle, otherwise the stored value.
   always_comb begin
      bus.read_data1 = '0;
      bus.read_data2 = '0;
      if (idxValid(int'(rs1))) begin
         bus.read_data1 = bypass1 ? bus.wb_data : regs_q[rs1];
      end
      if (idxValid(int'(rs2))) begin
         bus.read_data2 = bypass2 ? bus.wb_data : regs_q[rs2];
      end
   end

   // Hazard detection. A RAW on a register resolves in the same cycle only
   // when forwarding is on; a WAW resolves whenever rd is written back now,
   // because the new producer re-sets the busy bit on the same edge.
   always_comb begin
      raw1 = idxValid(int'(rs1)) && busy_q[rs1] && !bypass1;
      raw2 = idxValid(int'(rs2)) && busy_q[rs2] && !bypass2;
      waw  = bus.issue_rd_en && idxValid(int'(rd)) && busy_q[rd]
             && !(wbWrite && (int'(bus.wb_rd) == int'(rd)));
      hazard      = bus.issue_valid && (raw1 || raw2 || waw);
      issueAccept = bus.issue_valid && !hazard && reset_n;
   end

   assign bus.issue_ready = issueAccept;

   // Next busy state: clear on write-back first, then set for an accepted
   // producer so a same-edge set and clear leaves the bit set. The count is
   // the popcount of the next state so it always matches busy_vec.
   always_comb begin
      busy_d = busy_q;
      if (wbWrite) begin
         busy_d[bus.wb_rd] = 1'b0;
      end
      if (issueAccept && bus.issue_rd_en && idxValid(int'(rd))) begin
         busy_d[rd] = 1'b1;
      end
      busy_d[0] = 1'b0;

      pendingCount_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         pendingCount_d = pendingCount_d + (ADDR_W+1)'(busy_d[i]);
      end

      wbUnexpected_d = wbWrite && !busy_q[bus.wb_rd];
   end

   // State update. Reset wipes data and scoreboard and discards any
   // write-back presented on the same edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q         <= '0;
         pendingCount_q <= '0;
         wbUnexpected_q <= 1'b0;
      end else begin
         if (wbWrite) begin
            regs_q[bus.wb_rd] <= bus.wb_data;
         end
         busy_q         <= busy_d;
         pendingCount_q <= pendingCount_d;
         wbUnexpected_q <= wbUnexpected_d;
      end
   end

   assign bus.busy_vec      = busy_q;
   assign bus.pending_count = pendingCount_q;
   assign bus.wb_unexpected = wbUnexpected_q;

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- DATA_W, 64, register data width.
- NUM_REGS, 32, register count; register 0 is hardwired zero.
- ADDR_W, 5, register index width; NUM_REGS SHALL be <= 2**ADDR_W.
- BYPASS, 1, enables write-to-read forwarding; 0 disables it.

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- instruction  in  32  rs1=[19:15], rs2=[24:20], rd=[11:7].
- issue_valid  in  1  instruction offered for issue.
- issue_rd_en  in  1  instruction writes rd.
- issue_ready  out  1  issue accepted this cycle.
- read_data1  out  DATA_W  rs1 operand, combinational.
- read_data2  out  DATA_W  rs2 operand, combinational.
- wb_valid  in  1  write-back strobe.
- wb_rd  in  ADDR_W  write-back register index.
- wb_data  in  DATA_W  write-back data.
- busy_vec  out  NUM_REGS  per-register pending-write bits.
- pending_count  out  ADDR_W+1  number of set busy bits.
- wb_unexpected  out  1  registered pulse: write-back to a non-busy register.

REQ-003 One clock and one reset SHALL exist: reset is synchronous and active-low, named reset_n; the clock is named clk.

Function
REQ-004 Reads SHALL be combinational from the current state; a read of index 0, or of an index >= NUM_REGS, SHALL return 0.
REQ-005 When BYPASS=1, wb_valid=1 and wb_rd equals a nonzero read index, that read port SHALL return wb_data in the same cycle.
REQ-006 When BYPASS=0, reads SHALL return the pre-edge value; written data becomes visible the cycle after the write.
REQ-007 On a rising edge with wb_valid=1 and wb_rd nonzero and < NUM_REGS, the register SHALL take wb_data and busy[wb_rd] SHALL clear.
REQ-008 A write-back to index 0 or an out-of-range index SHALL be ignored.
REQ-009 hazard is internal and SHALL be true when issue_valid=1 and any of the following holds:
- RAW: busy[rs1] or busy[rs2] for a nonzero index, unless that register is being written this cycle with BYPASS=1.
- WAW: issue_rd_en=1, rd nonzero, and busy[rd] set, with no same-cycle write-back to rd.
REQ-010 issue_ready SHALL equal issue_valid AND NOT hazard; 0 when issue_valid=0.
REQ-011 When issue_ready=1, issue_rd_en=1 and rd is nonzero, busy[rd] SHALL set on the next edge.
REQ-012 A same-edge set and clear of the same register SHALL leave busy set (the new producer wins).
REQ-013 busy[0] SHALL be constantly 0.
REQ-014 pending_count SHALL equal the popcount of busy_vec after each edge, with range 0..NUM_REGS-1, and SHALL never wrap.
REQ-015 wb_unexpected SHALL pulse 1 for exactly the cycle after an edge where wb_valid=1, wb_rd nonzero and in range, and busy[wb_rd] was 0; the data SHALL still be written.
REQ-016 There SHALL be no internal stall queue: a refused issue is simply not recorded, and the source holds instruction until issue_ready=1.

Reset
REQ-017 On an edge with reset_n=0, all registers SHALL reset to 0, busy_vec to 0, pending_count to 0, and wb_unexpected to 0.
REQ-018 During reset, issue_ready SHALL be 0 and write-backs SHALL be discarded.
REQ-019 Reset asserted mid-operation SHALL drop all pending bits with no late write-back effect.
REQ-020 After reset_n returns to 1, the first edge SHALL operate normally.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then write x31=64'hDEAD_BEEF and x30=64'h1234. Issue instruction 32'h01EF_8000 -> read_data1=DEAD_BEEF, read_data2=1234, issue_ready=1.
- Issue with rd=5 (issue_rd_en=1), then instruction with rs1=5 -> busy_vec[5]=1, pending_count=1, issue_ready=0 until write-back.
- wb_valid, wb_rd=5, wb_data=64'hA5 in the same cycle as the rs1=5 read -> BYPASS=1: read_data1=A5, issue_ready=1. BYPASS=0: ready the next cycle.
- Write x0=64'hFFFF, then read rs1=0 -> read_data1=0, busy_vec[0]=0, wb_unexpected=0.
- Write-back to x7 while not busy -> x7 updated, wb_unexpected=1 for one cycle.
- Same-edge issue to rd=9 and write-back to 9 -> busy[9]=1 and the data written. Then reset_n=0 for 1 cycle -> all read data 0, pending_count=0.
